switch_egress_scheduler: RTL

- Round-robin drain scheduler for the four-port switch egress.
- Watches each port's ready flag, issues one-cycle read strobes to the granted port's FIFO and captures the returned word.
- Presents the word on a single egress channel with valid/ready handshake, tagged with the source port.
- Supports bounded bursts per grant so no port starves the others.

---
 rtl/switch_egress_scheduler_if.sv | 42 ++++
 rtl/switch_egress_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/switch_egress_scheduler_if.sv
// Bundle of the port-FIFO drain signals and the egress word channel.
// The scheduler uses the master view; the port FIFOs and downstream sink
// together form the slave view.
//
// Egress handshake: a word transfers on a rising edge where egress_valid and
// egress_ready are both high. Once egress_valid rises, it stays high and
// egress_data/egress_port stay stable until that transfer. egress_ready may
// change freely and never combinationally depends on egress_valid.
interface switch_egress_scheduler_if #(
  parameter int NUM_OF_PORTS = 4,
  parameter int WORD_WIDTH   = 8
);
  localparam int PORT_W = $clog2(NUM_OF_PORTS);

  logic [NUM_OF_PORTS-1:0]            port_ready;
  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_data;
  logic [NUM_OF_PORTS-1:0]            port_read;
  logic [WORD_WIDTH-1:0]              egress_data;
  logic [PORT_W-1:0]                  egress_port;
  logic                               egress_valid;
  logic                               egress_ready;

  modport master (
    input  port_ready,
    input  port_data,
    input  egress_ready,
    output port_read,
    output egress_data,
    output egress_port,
    output egress_valid
  );

  modport slave (
    output port_ready,
    output port_data,
    output egress_ready,
    input  port_read,
    input  egress_data,
    input  egress_port,
    input  egress_valid
  );
endinterface

// File: rtl/switch_egress_scheduler.sv
// Round-robin drain scheduler for the switch egress. Grants one port at a
// time, strobes that port's FIFO, captures the returned word after the read
// latency and offers it downstream tagged with its source port. A grant keeps
// draining the same port for up to MAX_BURST words before rotating.
module switch_egress_scheduler #(
  parameter int NUM_OF_PORTS = 4,
  parameter int WORD_WIDTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sched_en,
  switch_egress_scheduler_if.master   bus,
  output logic                        busy,
  output logic [1:0]                  state_dbg
);

  localparam int PORT_W  = $clog2(NUM_OF_PORTS);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int WAIT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PORT_W-1:0]   grant_q, grant_d;
  logic [PORT_W-1:0]   last_grant_q, last_grant_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [PORT_W-1:0]   eport_q, eport_d;
  logic                valid_q, valid_d;

  // Round-robin search results.
  logic                rr_found;
  logic [PORT_W-1:0]   rr_pick;
  logic [PORT_W-1:0]   rr_idx;

  // Same-port continuation decision taken at the HOLD handshake.
  logic                cont;

  // Find the first ready port after last_grant, wrapping modulo NUM_OF_PORTS.
  // The index wraps for free because NUM_OF_PORTS is a power of two; the
  // last iteration revisits last_grant itself.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant_q;
    rr_idx   = last_grant_q;
    for (int i = 1; i <= NUM_OF_PORTS; i++) begin
      rr_idx = last_grant_q + PORT_W'(i);
      if (!rr_found && bus.port_ready[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Keep draining the granted port only while enabled, it still has data and
  // this grant has budget left after the word being handed over now.
  always_comb begin
    cont = sched_en && bus.port_ready[grant_q] &&
           ((int'(burst_cnt_q) + 1) < MAX_BURST);
  end

  // Next-state and datapath updates for the drain FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    data_d       = data_q;
    eport_d      = eport_q;
    valid_d      = valid_q;

    case (state_q)
      S_IDLE: begin
        if (sched_en && rr_found) begin
          grant_d     = rr_pick;
          burst_cnt_d = '0;
          state_d     = S_READ;
        end
      end

      S_READ: begin
        // The strobe is issued during this single cycle; the counter then
        // covers the remaining FIFO latency.
        wait_cnt_d = WAIT_W'(RD_LATENCY - 1);
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          data_d  = bus.port_data[int'(grant_q)*WORD_WIDTH +: WORD_WIDTH];
          eport_d = grant_q;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      S_HOLD: begin
        if (bus.egress_ready) begin
          valid_d     = 1'b0;
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
          if (cont) begin
            state_d = S_READ;
          end else begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any word being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= PORT_W'(NUM_OF_PORTS - 1);
      burst_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      data_q       <= '0;
      eport_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      data_q       <= data_d;
      eport_q      <= eport_d;
      valid_q      <= valid_d;
    end
  end

  // One-hot read strobe, only ever driven from the READ state.
  always_comb begin
    bus.port_read = '0;
    if (state_q == S_READ) begin
      bus.port_read[grant_q] = 1'b1;
    end
  end

  assign bus.egress_data  = data_q;
  assign bus.egress_port  = eport_q;
  assign bus.egress_valid = valid_q;
  assign busy             = (state_q != S_IDLE);
  assign state_dbg        = state_q;

endmodule
